// File: rtl/resp_merger.sv
// Response merger: reorders SRAM and MISR completions back into issue order and
// presents them through a single registered response stage toward the AXI side.
module resp_merger #(
  parameter int NBIT_DATA       = 32,
  parameter int NBIT_AXI_WIDTH  = 64,
  parameter int USER_AXI_WIDTH  = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      issue_valid_i,
  input  logic                      issue_misr_i,
  input  logic                      issue_we_i,
  output logic                      issue_ready_o,
  input  logic                      sram_rvalid_i,
  input  logic [NBIT_AXI_WIDTH-1:0] sram_rdata_i,
  input  logic [USER_AXI_WIDTH-1:0] sram_ruser_i,
  input  logic                      misr_rvalid_i,
  input  logic [NBIT_DATA-1:0]      misr_rdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic                      rsp_we_o,
  output logic [NBIT_AXI_WIDTH-1:0] rsp_data_o,
  output logic [USER_AXI_WIDTH-1:0] rsp_user_o,
  output logic                      spurious_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int ENT_W = NBIT_AXI_WIDTH + USER_AXI_WIDTH;
  localparam int NTGT  = 2;  // target 0 = SRAM, target 1 = MISR

  // ---------------- order FIFO: {misr, we} per issued transaction ----------------
  logic [1:0]     ord_mem [MAX_OUTSTANDING];
  logic [PTR_W:0] ord_wptr_reg;
  logic [PTR_W:0] ord_rptr_reg;
  logic           ord_empty;
  logic           ord_full;
  logic           ord_push;
  logic           load;
  logic [1:0]     ord_head;
  logic           head_misr;
  logic           head_we;

  assign ord_empty     = (ord_wptr_reg == ord_rptr_reg);
  assign ord_full      = (ord_wptr_reg[PTR_W] != ord_rptr_reg[PTR_W]) &&
                         (ord_wptr_reg[PTR_W-1:0] == ord_rptr_reg[PTR_W-1:0]);
  assign issue_ready_o = !ord_full;
  assign ord_push      = issue_valid_i && issue_ready_o;
  assign ord_head      = ord_mem[ord_rptr_reg[PTR_W-1:0]];
  assign head_misr     = ord_head[1];
  assign head_we       = ord_head[0];

  always_ff @(posedge clk_i) begin
    if (ord_push) begin
      ord_mem[ord_wptr_reg[PTR_W-1:0]] <= {issue_misr_i, issue_we_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ord_wptr_reg <= '0;
      ord_rptr_reg <= '0;
    end else begin
      if (ord_push) begin
        ord_wptr_reg <= ord_wptr_reg + 1'b1;
      end
      if (load) begin
        ord_rptr_reg <= ord_rptr_reg + 1'b1;
      end
    end
  end

  // ---------------- per-target completion path ----------------
  logic [NBIT_AXI_WIDTH-1:0] misr_ext;
  logic [NTGT-1:0]           cmp_valid;
  logic [ENT_W-1:0]          cmp_ent [NTGT];
  logic [ENT_W-1:0]          src_ent [NTGT];
  logic [NTGT-1:0]           issue_hit;
  logic [NTGT-1:0]           accept;
  logic [NTGT-1:0]           head_sel;
  logic [NTGT-1:0]           tgt_ready;
  logic [NTGT-1:0]           buf_empty;

  assign misr_ext     = NBIT_AXI_WIDTH'(misr_rdata_i);
  assign cmp_valid[0] = sram_rvalid_i;
  assign cmp_valid[1] = misr_rvalid_i;
  assign cmp_ent[0]   = {sram_rdata_i, sram_ruser_i};
  assign cmp_ent[1]   = {misr_ext, {USER_AXI_WIDTH{1'b0}}};

  genvar gi;
  generate
    for (gi = 0; gi < NTGT; gi = gi + 1) begin : g_tgt
      logic [ENT_W-1:0] buf_mem [MAX_OUTSTANDING];
      logic [PTR_W:0]   buf_wptr_reg;
      logic [PTR_W:0]   buf_rptr_reg;
      logic [PTR_W:0]   out_cnt_reg;
      logic             bypass;
      logic             buf_push;
      logic             buf_pop;

      assign issue_hit[gi] = ord_push && (issue_misr_i == 1'(gi));
      // A completion only counts if its target still owes one; otherwise it is spurious.
      assign accept[gi]    = cmp_valid[gi] && (out_cnt_reg != '0);
      assign head_sel[gi]  = !ord_empty && (head_misr == 1'(gi));
      assign buf_empty[gi] = (buf_wptr_reg == buf_rptr_reg);
      assign tgt_ready[gi] = head_sel[gi] && (!buf_empty[gi] || accept[gi]);

      // With an empty buffer the arriving completion belongs to the head, so it goes
      // straight to the response register and skips the buffer entirely.
      assign bypass   = load && head_sel[gi] && buf_empty[gi];
      assign buf_push = accept[gi] && !bypass;
      assign buf_pop  = load && head_sel[gi] && !buf_empty[gi];
      assign src_ent[gi] = buf_empty[gi] ? cmp_ent[gi]
                                         : buf_mem[buf_rptr_reg[PTR_W-1:0]];

      always_ff @(posedge clk_i) begin
        if (buf_push) begin
          buf_mem[buf_wptr_reg[PTR_W-1:0]] <= cmp_ent[gi];
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          buf_wptr_reg <= '0;
          buf_rptr_reg <= '0;
          out_cnt_reg  <= '0;
        end else begin
          if (buf_push) begin
            buf_wptr_reg <= buf_wptr_reg + 1'b1;
          end
          if (buf_pop) begin
            buf_rptr_reg <= buf_rptr_reg + 1'b1;
          end
          out_cnt_reg <= out_cnt_reg + {{PTR_W{1'b0}}, issue_hit[gi]}
                                     - {{PTR_W{1'b0}}, accept[gi]};
        end
      end
    end
  endgenerate

  // ---------------- registered response stage ----------------
  logic [ENT_W-1:0] load_ent;

  assign load     = (|tgt_ready) && (!rsp_valid_o || rsp_ready_i);
  assign load_ent = head_misr ? src_ent[1] : src_ent[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_we_o    <= 1'b0;
      rsp_data_o  <= '0;
      rsp_user_o  <= '0;
      spurious_o  <= 1'b0;
    end else begin
      if (load) begin
        rsp_valid_o <= 1'b1;
        rsp_we_o    <= head_we;
        rsp_data_o  <= head_we ? '0 : load_ent[ENT_W-1 -: NBIT_AXI_WIDTH];
        rsp_user_o  <= load_ent[USER_AXI_WIDTH-1:0];
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
      spurious_o <= |(cmp_valid & ~accept);
    end
  end

endmodule
